rng_seq_ctrl: RTL and testbench

Sequencer and arbiter for the tag random-number generator. Accepts single-cycle requests from SCU and decoder (seed load, RN1, RN16, handle). Converts each request into one glitch-free, register-driven strobe on the generator's clock-like inputs: init_done, rn1_update, rn16_update, handle_update. Strobes are serialized with a guaranteed settle gap, so every capture edge sees a stable shift register. Sits between SCU/CMD_PARSE and the RNG block, clocked by DOUB_BLF.

---
 rtl/rng_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_rng_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_seq_ctrl.sv
// Request sequencer/arbiter for the tag RNG: one flop-driven strobe per op, followed by a settle gap.
// Optional build macro RNG_SEED_GUARD_EN replaces an all-zero seed with 16'hACE1.
module rng_seq_ctrl #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic        DOUB_BLF,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic [15:0] crc_calc,
    input  logic        handle_req,
    input  logic        rn16_req,
    input  logic        rn1_req,
    output logic        init_done,
    output logic [15:0] seed,
    output logic        handle_update,
    output logic        rn16_update,
    output logic        rn1_update,
    output logic        busy,
    output logic        done,
    output logic [1:0]  done_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_W - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [1:0]  op_id, op_id_nxt;
    logic [3:0]  pend, pend_nxt;
    logic [3:0]  req_vec;
    logic [3:0]  avail;
    logic        grant;
    logic [1:0]  grant_id;
    logic [3:0]  strobe;
    logic        op_end;

    function automatic logic [15:0] seed_sel(input logic [15:0] crc);
`ifdef RNG_SEED_GUARD_EN
        // An all-zero seed would lock the LFSR up permanently.
        return (crc == 16'h0000) ? 16'hACE1 : crc;
`else
        return crc;
`endif
    endfunction

    // Bit index doubles as op id: 0 init, 1 handle, 2 rn16, 3 rn1.
    assign req_vec = {rn1_req, rn16_req, handle_req, init_req};
    assign avail   = pend | req_vec;
    assign grant   = (state == IDLE) && (|avail);
    assign op_end  = (state == GAP) && (cnt == 4'd0);

    always_comb begin
        grant_id = 2'd0;
        if (avail[0])      grant_id = 2'd0;
        else if (avail[1]) grant_id = 2'd1;
        else if (avail[2]) grant_id = 2'd2;
        else if (avail[3]) grant_id = 2'd3;
    end

    always_ff @(posedge DOUB_BLF or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_id <= 2'd0;
            pend  <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_id <= op_id_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_id_nxt = op_id;
        pend_nxt  = avail;
        if (grant) pend_nxt[grant_id] = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_LOAD;
                    op_id_nxt = grant_id;
                end
            end
            PULSE: begin
                if (cnt == 4'd0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            GAP: begin
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE) | (|pend);
    end

    // Strobes feed RNG clock pins, so they come straight from flops decoded off the next state.
    always_ff @(posedge DOUB_BLF or negedge rst_n) begin
        if (!rst_n) begin
            strobe  <= 4'd0;
            done    <= 1'b0;
            done_id <= 2'd0;
            seed    <= 16'h0000;
        end else begin
            strobe <= (state_nxt == PULSE) ? (4'b0001 << op_id_nxt) : 4'd0;
            done   <= op_end;
            if (op_end) done_id <= op_id;
            if (grant && (grant_id == 2'd0)) seed <= seed_sel(crc_calc);
        end
    end

    assign init_done     = strobe[0];
    assign handle_update = strobe[1];
    assign rn16_update   = strobe[2];
    assign rn1_update    = strobe[3];

endmodule

// File: tb/tb_rng_seq_ctrl.sv
// Scoreboard bench for rng_seq_ctrl: a 2/2 timing instance and a 1/1 timing instance.
module tb_rng_seq_ctrl;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] seed;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_req = 1'b0, handle_req = 1'b0, rn16_req = 1'b0, rn1_req = 1'b0;
    logic [15:0] crc_calc = 16'h0000;
    logic        init_done, handle_update, rn16_update, rn1_update, busy, done;
    logic [15:0] seed;
    logic [1:0]  done_id;

    logic        b_init_req = 1'b0, b_handle_req = 1'b0, b_rn16_req = 1'b0, b_rn1_req = 1'b0;
    logic [15:0] b_crc = 16'h0000;
    logic        b_init_done, b_handle_update, b_rn16_update, b_rn1_update, b_busy, b_done;
    logic [15:0] b_seed;
    logic [1:0]  b_done_id;

    int checks = 0;
    int failures = 0;
    exp_t q[$];
    exp_t qb[$];
    logic [15:0] exp_seed = 16'h0000;

    int cyc = 0, rise_cyc = 0, last_width = 0, last_id = 0, done_cnt = 0, rise_cnt = 0;
    logic [3:0] prev_strb = 4'd0;
    int bcyc = 0, brise_cyc = 0, bwidth = 0, bdone_cnt = 0, blast_done = -1;
    logic bprev = 1'b0;

    rng_seq_ctrl #(.PULSE_W(2), .GAP_W(2)) dut (
        .DOUB_BLF(clk), .rst_n(rst_n), .init_req(init_req), .crc_calc(crc_calc),
        .handle_req(handle_req), .rn16_req(rn16_req), .rn1_req(rn1_req),
        .init_done(init_done), .seed(seed), .handle_update(handle_update),
        .rn16_update(rn16_update), .rn1_update(rn1_update), .busy(busy),
        .done(done), .done_id(done_id)
    );

    rng_seq_ctrl #(.PULSE_W(1), .GAP_W(1)) dut_b (
        .DOUB_BLF(clk), .rst_n(rst_n), .init_req(b_init_req), .crc_calc(b_crc),
        .handle_req(b_handle_req), .rn16_req(b_rn16_req), .rn1_req(b_rn1_req),
        .init_done(b_init_done), .seed(b_seed), .handle_update(b_handle_update),
        .rn16_update(b_rn16_update), .rn1_update(b_rn1_update), .busy(b_busy),
        .done(b_done), .done_id(b_done_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, req);
        end
    endtask

    // Monitor for the 2/2 instance
    always @(negedge clk) begin
        logic [3:0] s;
        exp_t e;
        if (!rst_n) begin
            prev_strb = 4'd0;
        end else begin
            cyc++;
            s = {rn1_update, rn16_update, handle_update, init_done};
            if (s != 4'd0) begin
                chk("strobe_onehot", 32'($onehot(s)), 32'd1);
                if (prev_strb == 4'd0) begin
                    rise_cyc = cyc;
                    last_width = 1;
                    rise_cnt++;
                    for (int i = 0; i < 4; i++) if (s[i]) last_id = i;
                end else begin
                    last_width++;
                end
            end
            if (done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got done_id=%0d expected=no_done", done_id);
                end else begin
                    e = q.pop_front();
                    chk("done_id", 32'(done_id), 32'(e.id));
                    chk("seed_at_done", 32'(seed), 32'(e.seed));
                    chk("strobe_id", 32'(last_id), 32'(e.id));
                    chk("strobe_width", 32'(last_width), 32'd2);
                    chk("done_latency", 32'(cyc - rise_cyc), 32'd4);
                end
            end
            prev_strb = s;
        end
    end

    // Monitor for the 1/1 instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bprev = 1'b0;
        end else begin
            bcyc++;
            if (b_rn1_update) begin
                if (!bprev) begin
                    brise_cyc = bcyc;
                    bwidth = 1;
                end else begin
                    bwidth++;
                end
            end
            if (b_done) begin
                bdone_cnt++;
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_done got done_id=%0d expected=no_done", b_done_id);
                end else begin
                    e = qb.pop_front();
                    chk("b_done_id", 32'(b_done_id), 32'(e.id));
                    chk("b_strobe_width", 32'(bwidth), 32'd1);
                    chk("b_done_latency", 32'(bcyc - brise_cyc), 32'd2);
                    if (blast_done >= 0) chk("b_done_period", 32'(bcyc - blast_done), 32'd3);
                end
                blast_done = bcyc;
            end
            bprev = b_rn1_update;
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(n >= 100), 32'd0);
    endtask

    task automatic drain_b(input string name);
        int n;
        n = 0;
        while ((qb.size() != 0 || b_busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(n >= 100), 32'd0);
    endtask

    initial begin
        int d0, r0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({init_done, handle_update, rn16_update, rn1_update}), 32'd0);
        chk("rst_seed", 32'(seed), 32'h0000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // seed load
        init_req = 1'b1;
        crc_calc = 16'h1D0F;
        exp_seed = 16'h1D0F;
        q.push_back('{2'd0, exp_seed});
        @(negedge clk);
        init_req = 1'b0;
        crc_calc = 16'hFFFF;
        drain("init");
        chk("init_seed", 32'(seed), 32'h1D0F);
        chk("init_busy_after", 32'(busy), 32'd0);

        // three requests in one cycle
        @(negedge clk);
        rn1_req = 1'b1;
        rn16_req = 1'b1;
        handle_req = 1'b1;
        q.push_back('{2'd1, exp_seed});
        q.push_back('{2'd2, exp_seed});
        q.push_back('{2'd3, exp_seed});
        @(negedge clk);
        rn1_req = 1'b0;
        rn16_req = 1'b0;
        handle_req = 1'b0;
        drain("simul");

        // repeated rn16 during a handle op merge into one
        @(negedge clk);
        d0 = done_cnt;
        handle_req = 1'b1;
        q.push_back('{2'd1, exp_seed});
        q.push_back('{2'd2, exp_seed});
        @(negedge clk); handle_req = 1'b0; rn16_req = 1'b1;
        @(negedge clk); rn16_req = 1'b0;
        @(negedge clk); rn16_req = 1'b1;
        @(negedge clk); rn16_req = 1'b0;
        @(negedge clk); rn16_req = 1'b1;
        @(negedge clk); rn16_req = 1'b0;
        drain("merge");
        chk("merge_done_count", 32'(done_cnt - d0), 32'd2);

        // reset in the first cycle of an rn16 strobe
        @(negedge clk);
        d0 = done_cnt;
        rn16_req = 1'b1;
        @(negedge clk);
        rn16_req = 1'b0;
        chk("rst_mid_strobe_before", 32'(rn16_update), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_strobe_cut", 32'(rn16_update), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rise_cnt;
        repeat (10) @(negedge clk);
        chk("rst_mid_no_strobe", 32'(rise_cnt - r0), 32'd0);
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_mid_busy_after", 32'(busy), 32'd0);

        // zero CRC seed
        init_req = 1'b1;
        crc_calc = 16'h0000;
`ifdef RNG_SEED_GUARD_EN
        exp_seed = 16'hACE1;
`else
        exp_seed = 16'h0000;
`endif
        q.push_back('{2'd0, exp_seed});
        @(negedge clk);
        init_req = 1'b0;
        crc_calc = 16'h5555;
        drain("zero_seed");
        chk("zero_seed_value", 32'(seed), 32'(exp_seed));

        // continuous rn1 on the 1/1 instance: held 9 edges gives 4 ops
        @(negedge clk);
        d0 = bdone_cnt;
        b_rn1_req = 1'b1;
        for (int i = 0; i < 4; i++) qb.push_back('{2'd3, 16'h0000});
        repeat (9) @(negedge clk);
        b_rn1_req = 1'b0;
        drain_b("cont_rn1");
        chk("cont_rn1_done_count", 32'(bdone_cnt - d0), 32'd4);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(q.size() + qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
